// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver: frame layout, FSM state encodings, parity helper.
// The optional UART_RX_MAJORITY_VOTE_EN macro is consumed by uart_rx_bit_sampler.
`timescale 1ns/1ps
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_IDX_W     = $clog2(UART_DATA_BITS);

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_START  = 3'd1;
  localparam logic [2:0] ENC_DATA   = 3'd2;
  localparam logic [2:0] ENC_PARITY = 3'd3;
  localparam logic [2:0] ENC_STOP   = 3'd4;
  localparam logic [2:0] ENC_BREAK  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ENC_IDLE,
    S_START  = ENC_START,
    S_DATA   = ENC_DATA,
    S_PARITY = ENC_PARITY,
    S_STOP   = ENC_STOP,
    S_BREAK  = ENC_BREAK
  } rx_state_t;

  // Parity bit a correct transmitter appends to data.
  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data,
                                       input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Line synchronizer, per-bit counter and mid-bit sample strobe for the UART receiver.
// With UART_RX_MAJORITY_VOTE_EN defined, each sample is a 2-of-3 vote of consecutive synced values.
`timescale 1ns/1ps
module uart_rx_bit_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
)
(
  input  logic clk,
  input  logic rst_n,
  input  logic serial_in,
  input  logic i_run,
  input  logic i_half,
  output logic o_rxs,
  output logic o_sample_en,
  output logic o_sample_bit
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_target;
  logic             w_strobe;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {2{UART_IDLE_LEVEL}};
    else        r_sync <= {r_sync[0], serial_in};
  end

  assign o_rxs = r_sync[1];

  // The start bit is checked half a bit in; every later sample is a full bit after the previous one.
  assign w_target = i_half ? CNT_HALF : CNT_LAST;
  assign w_strobe = i_run && (r_cnt == w_target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (!i_run || w_strobe) r_cnt <= '0;
    else                       r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_sample_en = w_strobe;

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Window ends at the strobe so the decision point, and rx_valid latency, does not move.
  logic [1:0] r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hist <= {2{UART_IDLE_LEVEL}};
    else        r_hist <= {r_hist[0], o_rxs};
  end

  assign o_sample_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & o_rxs) | (r_hist[0] & o_rxs);
`else
  assign o_sample_bit = o_rxs;
`endif

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART SIPO receiver: start, 8 data bits LSB first, parity, stop; byte and status as a 1-cycle pulse.
// Optional build macro UART_RX_MAJORITY_VOTE_EN enables 3-sample voting. CLKS_PER_BIT must be even and >= 8.
`timescale 1ns/1ps
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
)
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      serial_in,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      rx_valid,
  output logic                      parity_error,
  output logic                      framing_error,
  output logic                      rx_busy
);

  rx_state_t r_state;
  rx_state_t w_state_next;

  logic w_rxs;
  logic w_sample_en;
  logic w_sample_bit;
  logic w_run;
  logic w_half;
  logic w_shift_en;
  logic w_par_en;
  logic w_done;
  logic w_last_bit;

  logic [UART_IDX_W-1:0]     r_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_par_bit;
  logic [UART_DATA_BITS-1:0] r_data_out;
  logic                      r_valid;
  logic                      r_parity_error;
  logic                      r_framing_error;

  uart_rx_bit_sampler #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_sampler (
    .clk          (clk),
    .rst_n        (rst_n),
    .serial_in    (serial_in),
    .i_run        (w_run),
    .i_half       (w_half),
    .o_rxs        (w_rxs),
    .o_sample_en  (w_sample_en),
    .o_sample_bit (w_sample_bit)
  );

  assign w_last_bit = (r_idx == UART_IDX_W'(UART_DATA_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default assignment first keeps this block purely combinational (no inferred latch).
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_rxs == UART_START_LEVEL) w_state_next = S_START;
      S_START:  if (w_sample_en)
                  w_state_next = (w_sample_bit == UART_START_LEVEL) ? S_DATA : S_IDLE;
      S_DATA:   if (w_sample_en && w_last_bit) w_state_next = S_PARITY;
      S_PARITY: if (w_sample_en) w_state_next = S_STOP;
      S_STOP:   if (w_sample_en)
                  w_state_next = (w_sample_bit == UART_STOP_LEVEL) ? S_IDLE : S_BREAK;
      // A line stuck low must go high before another start can be recognised.
      S_BREAK:  if (w_rxs == UART_IDLE_LEVEL) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_run      = 1'b0;
    w_half     = 1'b0;
    w_shift_en = 1'b0;
    w_par_en   = 1'b0;
    w_done     = 1'b0;
    rx_busy    = (r_state != S_IDLE);
    unique case (r_state)
      S_START:  begin w_run = 1'b1; w_half = 1'b1; end
      S_DATA:   begin w_run = 1'b1; w_shift_en = w_sample_en; end
      S_PARITY: begin w_run = 1'b1; w_par_en   = w_sample_en; end
      S_STOP:   begin w_run = 1'b1; w_done     = w_sample_en; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_idx <= '0;
    else if (r_state != S_DATA) r_idx <= '0;
    else if (w_shift_en)       r_idx <= r_idx + UART_IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_par_bit <= 1'b0;
    end else begin
      if (w_shift_en) r_shift[r_idx] <= w_sample_bit;
      if (w_par_en)   r_par_bit      <= w_sample_bit;
    end
  end

  // Result registers load on the stop sample; they become visible together with rx_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid         <= 1'b0;
      r_data_out      <= '0;
      r_parity_error  <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_data_out      <= r_shift;
        r_parity_error  <= (r_par_bit != uart_parity(r_shift, PARITY_ODD));
        r_framing_error <= (w_sample_bit != UART_STOP_LEVEL);
      end
    end
  end

  assign data_out      = r_data_out;
  assign rx_valid      = r_valid;
  assign parity_error  = r_parity_error;
  assign framing_error = r_framing_error;

endmodule
